main_bus_arbiter: RTL and testbench



---
 rtl/main_bus_pkg.sv | 43 ++++
 rtl/main_bus_rr_pick.sv | 24 ++
 rtl/main_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_main_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_bus_pkg.sv
// main_bus_pkg: shared state type, limits and round-robin search helper
// for the main_bus arbiter and its pick logic.
package main_bus_pkg;

  localparam int MAIN_BUS_MAX_MASTERS = 16;
  localparam int MAIN_BUS_IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } arb_state_t;

  typedef struct packed {
    logic                      valid;
    logic [MAIN_BUS_IDX_W-1:0] idx;
  } rr_result_t;

  // Finds the first set request at or after ptr, wrapping over all 16 slots.
  // Slots above the real master count are tied low by the caller, so wrapping
  // over 16 visits the populated masters in the same order as wrapping over
  // NUM_MASTERS, which keeps non-power-of-2 configurations fair.
  function automatic rr_result_t rr_select(
    input logic [MAIN_BUS_MAX_MASTERS-1:0] req,
    input logic [MAIN_BUS_IDX_W-1:0]       ptr
  );
    rr_result_t res;
    int         slot;
    res = '0;
    for (int k = 0; k < MAIN_BUS_MAX_MASTERS; k++) begin
      slot = int'(ptr) + k;
      if (slot >= MAIN_BUS_MAX_MASTERS) begin
        slot = slot - MAIN_BUS_MAX_MASTERS;
      end
      if (!res.valid && req[slot]) begin
        res.valid = 1'b1;
        res.idx   = MAIN_BUS_IDX_W'(slot);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/main_bus_rr_pick.sv
// main_bus_rr_pick: combinational round-robin winner selection for the
// main_bus arbiter.
module main_bus_rr_pick
  import main_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDW         = 2
) (
  input  logic [NUM_MASTERS-1:0] bus_request,
  input  logic [IDW-1:0]         rr_ptr,
  output logic [IDW-1:0]         winner,
  output logic                   any_req
);

  rr_result_t pick;

  // Pick the first requester at or after the round-robin pointer.
  always_comb begin
    pick    = rr_select(MAIN_BUS_MAX_MASTERS'(bus_request), MAIN_BUS_IDX_W'(rr_ptr));
    winner  = IDW'(pick.idx);
    any_req = pick.valid;
  end

endmodule

// File: rtl/main_bus_arbiter.sv
// main_bus_arbiter: round-robin arbiter for the shared main_bus with a
// registered one-hot grant, idle turnaround cycles between owners and a
// per-tenure hold limit that force-releases a master keeping the bus.
module main_bus_arbiter
  import main_bus_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int MAX_HOLD    = 16,
  parameter  int TURNAROUND  = 1,
  localparam int IDW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [NUM_MASTERS-1:0] bus_request,
  output logic [NUM_MASTERS-1:0] bus_grant,
  output logic [IDW-1:0]         grant_id,
  output logic                   bus_busy,
  output logic                   hold_timeout
);

  localparam int             HCW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_MASTERS - 1);
  localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD);
  localparam logic [1:0]     TURN_LOAD  = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

  arb_state_t             state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [1:0]             turn_cnt_q, turn_cnt_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [IDW-1:0]         grant_id_d;
  logic                   busy_d;
  logic                   timeout_d;

  logic [IDW-1:0]         ptr_after;
  logic [IDW-1:0]         pick_ptr;
  logic [IDW-1:0]         winner;
  logic                   any_req;
  logic                   owner_req;
  logic                   limit_hit;
  logic                   do_grant;

  assign owner_req = bus_request[grant_id];
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT);

  // Pointer that follows the current owner, wrapped explicitly so that
  // non-power-of-2 master counts return to index 0 after the last master.
  always_comb begin
    ptr_after = '0;
    if (grant_id != LAST_ID) begin
      ptr_after = grant_id + IDW'(1);
    end
  end

  // While granted, arbitrate as if the pointer had already moved past the
  // owner; this only matters for the zero-turnaround back-to-back regrant.
  always_comb begin
    pick_ptr = rr_ptr_q;
    if (state_q == GRANT) begin
      pick_ptr = ptr_after;
    end
  end

  main_bus_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDW         (IDW)
  ) u_pick (
    .bus_request (bus_request),
    .rr_ptr      (pick_ptr),
    .winner      (winner),
    .any_req     (any_req)
  );

  // Next-state and next-output logic. The idle gap between owners is exactly
  // TURNAROUND cycles: the last TURN cycle arbitrates directly, and with no
  // turnaround the release edge hands the bus straight to the next winner.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    grant_d    = bus_grant;
    grant_id_d = grant_id;
    busy_d     = bus_busy;
    timeout_d  = 1'b0;
    do_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        do_grant = any_req;
      end
      GRANT: begin
        if (!owner_req || limit_hit) begin
          grant_d    = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          rr_ptr_d   = ptr_after;
          timeout_d  = owner_req;
          if (TURNAROUND == 0) begin
            state_d  = IDLE;
            do_grant = any_req;
          end else begin
            state_d    = TURN;
            turn_cnt_d = TURN_LOAD;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      TURN: begin
        if (turn_cnt_q == 2'd0) begin
          state_d  = IDLE;
          do_grant = any_req;
        end else begin
          turn_cnt_d = turn_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant) begin
      state_d    = GRANT;
      grant_d    = NUM_MASTERS'(1) << winner;
      grant_id_d = winner;
      busy_d     = 1'b1;
      hold_cnt_d = HCW'(1);
    end
  end

  // State and registered outputs; reset clears the bus immediately.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      turn_cnt_q   <= '0;
      bus_grant    <= '0;
      grant_id     <= '0;
      bus_busy     <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      bus_grant    <= grant_d;
      grant_id     <= grant_id_d;
      bus_busy     <= busy_d;
      hold_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_main_bus_arbiter.sv
// tb_main_bus_arbiter: directed and randomized checks of two arbiter
// configurations against a behavioural tenure model.
module tb_main_bus_arbiter;

  logic       clock = 1'b0;
  logic       resetN;
  logic [3:0] req_a;
  logic [2:0] req_b;
  logic [3:0] grant_a;
  logic [1:0] id_a;
  logic       busy_a, to_a;
  logic [2:0] grant_b;
  logic [1:0] id_b;
  logic       busy_b, to_b;

  int checks = 0;
  int errors = 0;

  // Model state per configuration (0: 4 masters, 1: 3 masters).
  int m_n  [2] = '{4, 3};
  int m_mh [2] = '{4, 5};
  int m_ta [2] = '{1, 0};
  int m_owner [2];
  int m_held  [2];
  int m_zeros [2];
  int m_ptr   [2];
  bit m_pulse [2];

  int         order_q[$];
  int         gaps_q[$];
  int         zrun;
  int         zero_after;
  bit         seen;
  int         last_id;
  logic [3:0] prev_g;
  logic [3:0] ra;
  logic [2:0] rb;
  int         idx;
  int         rr_exp [5] = '{0, 1, 2, 3, 0};
  int         b_exp  [4] = '{0, 1, 2, 0};
  logic [3:0] to_grant_exp [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
  logic       to_pulse_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clock = ~clock;

  main_bus_arbiter #(.NUM_MASTERS(4), .MAX_HOLD(4), .TURNAROUND(1)) dut_a (
    .clock        (clock),
    .resetN       (resetN),
    .bus_request  (req_a),
    .bus_grant    (grant_a),
    .grant_id     (id_a),
    .bus_busy     (busy_a),
    .hold_timeout (to_a)
  );

  main_bus_arbiter #(.NUM_MASTERS(3), .MAX_HOLD(5), .TURNAROUND(0)) dut_b (
    .clock        (clock),
    .resetN       (resetN),
    .bus_request  (req_b),
    .bus_grant    (grant_b),
    .grant_id     (id_b),
    .bus_busy     (busy_b),
    .hold_timeout (to_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_zeros[d] = 0;
      m_ptr[d]   = 0;
      m_pulse[d] = 1'b0;
    end
  endtask

  // One clock edge of the tenure model: an owner keeps the bus until its
  // request drops or it has held MAX_HOLD cycles; afterwards TURNAROUND empty
  // cycles pass before the next requester after the old owner is chosen.
  task automatic modelStep(input int d, input logic [3:0] r);
    bit found;
    int i;
    m_pulse[d] = 1'b0;
    if (m_owner[d] >= 0) begin
      if (!r[m_owner[d]] || (m_mh[d] > 0 && m_held[d] == m_mh[d])) begin
        m_pulse[d] = r[m_owner[d]];
        m_ptr[d]   = (m_owner[d] + 1) % m_n[d];
        m_owner[d] = -1;
        m_zeros[d] = m_ta[d];
      end else begin
        m_held[d]++;
      end
    end else if (m_zeros[d] > 0) begin
      m_zeros[d]--;
    end
    if (m_owner[d] < 0 && m_zeros[d] == 0) begin
      found = 1'b0;
      for (int k = 0; k < m_n[d]; k++) begin
        i = (m_ptr[d] + k) % m_n[d];
        if (!found && r[i]) begin
          found      = 1'b1;
          m_owner[d] = i;
          m_held[d]  = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [2:0] b);
    req_a = a;
    req_b = b;
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] eg_a;
    logic [2:0] eg_b;
    eg_a = (m_owner[0] >= 0) ? 4'(1 << m_owner[0]) : 4'b0000;
    eg_b = (m_owner[1] >= 0) ? 3'(1 << m_owner[1]) : 3'b000;
    chk({tag, ".a.grant"}, grant_a, eg_a);
    chk({tag, ".a.busy"}, busy_a, m_owner[0] >= 0);
    chk({tag, ".a.timeout"}, to_a, m_pulse[0]);
    if (m_owner[0] >= 0) chk({tag, ".a.id"}, id_a, m_owner[0]);
    chk({tag, ".b.grant"}, grant_b, eg_b);
    chk({tag, ".b.busy"}, busy_b, m_owner[1] >= 0);
    chk({tag, ".b.timeout"}, to_b, m_pulse[1]);
    if (m_owner[1] >= 0) chk({tag, ".b.id"}, id_b, m_owner[1]);
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    modelStep(0, req_a);
    modelStep(1, {1'b0, req_b});
    @(negedge clock);
    checkOutput(tag);
  endtask

  // Asserts reset between edges and expects the outputs to clear at once.
  task automatic doReset(input string tag);
    #2 resetN = 1'b0;
    #1;
    chk({tag, ".rst.a.grant"}, grant_a, 4'b0000);
    chk({tag, ".rst.a.busy"}, busy_a, 1'b0);
    chk({tag, ".rst.a.timeout"}, to_a, 1'b0);
    chk({tag, ".rst.a.id"}, id_a, 2'd0);
    chk({tag, ".rst.b.grant"}, grant_b, 3'b000);
    chk({tag, ".rst.b.busy"}, busy_b, 1'b0);
    modelReset();
    @(negedge clock);
    resetN = 1'b1;
  endtask

  // Grants must never be multi-hot in either configuration.
  always @(negedge clock) begin
    checks++;
    assert ($onehot0(grant_a) && $onehot0(grant_b)) else begin
      errors++;
      $error("[TB] FAIL onehot0: observed a=%b b=%b expected at most one bit", grant_a, grant_b);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting main_bus_arbiter bench");
    resetN = 1'b0;
    applyStimulus(4'b0000, 3'b000);
    modelReset();
    repeat (2) @(negedge clock);
    chk("reset.a.grant", grant_a, 4'b0000);
    chk("reset.a.id", id_a, 2'd0);
    chk("reset.a.busy", busy_a, 1'b0);
    chk("reset.a.timeout", to_a, 1'b0);
    chk("reset.b.grant", grant_b, 3'b000);
    resetN = 1'b1;

    // Latency: one cycle from request to registered grant.
    repeat (3) tick("idle");
    applyStimulus(4'b0100, 3'b000);
    #1 chk("lat.pre", grant_a, 4'b0000);
    tick("lat");
    chk("lat.grant", grant_a, 4'b0100);
    chk("lat.id", id_a, 2'd2);
    chk("lat.busy", busy_a, 1'b1);
    applyStimulus(4'b0000, 3'b000);
    repeat (2) tick("lat.rel");

    // Round robin: everyone requests, owners drop after 3 granted cycles.
    doReset("rr");
    order_q.delete();
    gaps_q.delete();
    zrun   = 0;
    seen   = 1'b0;
    prev_g = 4'b0000;
    applyStimulus(4'b1111, 3'b000);
    for (int c = 0; c < 18; c++) begin
      tick("rr");
      if (grant_a == 4'b0000) begin
        zrun++;
      end else begin
        if (prev_g == 4'b0000) begin
          order_q.push_back(int'(id_a));
          if (seen) gaps_q.push_back(zrun);
        end
        seen = 1'b1;
        zrun = 0;
      end
      prev_g = grant_a;
      if (m_owner[0] >= 0 && m_held[0] == 3)
        applyStimulus(4'b1111 & ~4'(1 << m_owner[0]), 3'b000);
      else
        applyStimulus(4'b1111, 3'b000);
    end
    chk("rr.tenures", order_q.size(), 5);
    for (int k = 0; k < order_q.size() && k < 5; k++)
      chk($sformatf("rr.order%0d", k), order_q[k], rr_exp[k]);
    chk("rr.gapcount", gaps_q.size(), 4);
    for (int k = 0; k < gaps_q.size(); k++)
      chk($sformatf("rr.gap%0d", k), gaps_q[k], 1);

    // Timeout: master 1 never lets go, master 3 waits behind it.
    doReset("to");
    applyStimulus(4'b1010, 3'b000);
    for (int c = 0; c < 6; c++) begin
      tick("to");
      chk($sformatf("to.grant%0d", c), grant_a, to_grant_exp[c]);
      chk($sformatf("to.pulse%0d", c), to_a, to_pulse_exp[c]);
    end

    // Reset mid-grant while master 3 owns the bus; arbitration restarts at 0.
    doReset("mid");
    applyStimulus(4'b1001, 3'b000);
    tick("mid.after");
    chk("mid.after.grant", grant_a, 4'b0001);
    chk("mid.after.id", id_a, 2'd0);

    // Master 0 drops its request exactly when the hold limit is reached.
    applyStimulus(4'b0001, 3'b000);
    repeat (3) tick("drop.hold");
    applyStimulus(4'b0000, 3'b000);
    tick("drop.rel");
    chk("drop.grant", grant_a, 4'b0000);
    chk("drop.timeout", to_a, 1'b0);
    tick("drop.after");
    chk("drop.after.timeout", to_a, 1'b0);

    // Three masters with no turnaround: back-to-back forced handovers.
    doReset("n3");
    order_q.delete();
    seen       = 1'b0;
    last_id    = -1;
    zero_after = 0;
    applyStimulus(4'b0000, 3'b111);
    for (int c = 0; c < 16; c++) begin
      tick("n3");
      if (grant_b == 3'b000) begin
        if (seen) zero_after++;
      end else begin
        if (!seen || int'(id_b) != last_id) order_q.push_back(int'(id_b));
        seen    = 1'b1;
        last_id = int'(id_b);
      end
    end
    chk("n3.tenures", order_q.size(), 4);
    for (int k = 0; k < order_q.size() && k < 4; k++)
      chk($sformatf("n3.order%0d", k), order_q[k], b_exp[k]);
    chk("n3.zero_cycles", zero_after, 0);

    // Randomized request traffic on both configurations.
    for (int c = 0; c < 400; c++) begin
      ra = req_a;
      rb = req_b;
      if ($urandom_range(0, 2) == 0) begin
        idx     = $urandom_range(0, 3);
        ra[idx] = ~ra[idx];
      end
      if ($urandom_range(0, 2) == 0) begin
        idx     = $urandom_range(0, 2);
        rb[idx] = ~rb[idx];
      end
      if ($urandom_range(0, 149) == 0) doReset("rand");
      applyStimulus(ra, rb);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
